// File: rtl/dphy_hs_data_rx_aligner.sv
// D-PHY HS receive byte aligner: hunts the SoT sync byte in the deserialized
// lane stream, locks its bit offset and emits byte-aligned payload until HS ends.
module dphy_hs_data_rx_aligner #(
  parameter logic [7:0] SYNC_BYTE    = 8'hB8,
  parameter int         SYNC_TIMEOUT = 16
) (
  input  logic       byte_clk,
  input  logic       byte_rst,
  input  logic       hs_enable,
  input  logic [7:0] raw_data,
  output logic [7:0] data,
  output logic       valid,
  output logic       sot,
  output logic       sync_err,
  output logic       locked,
  output logic [2:0] offset
);

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED, ERROR} state_t;

  state_t      state, state_next;
  logic [7:0]  prev_raw;
  logic [15:0] window;
  logic [7:0]  hunt_cnt;
  logic        first_byte;
  logic        match;
  logic [2:0]  match_k;
  logic        timeout;

  assign window  = {raw_data, prev_raw};
  assign timeout = (hunt_cnt == 8'(SYNC_TIMEOUT - 1));

  // Descending scan so the lowest matching offset is the one left standing;
  // bits below the candidate must be the HS-zero leader.
  always_comb begin
    match   = 1'b0;
    match_k = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if ((window[k +: 8] == SYNC_BYTE) &&
          ((window & ((16'd1 << k) - 16'd1)) == 16'd0)) begin
        match   = 1'b1;
        match_k = 3'(k);
      end
    end
  end

  always_ff @(posedge byte_clk) begin
    if (byte_rst) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hs_enable) state_next = HUNT;
      HUNT: begin
        if (!hs_enable)   state_next = IDLE;
        else if (match)   state_next = LOCKED;
        else if (timeout) state_next = ERROR;
      end
      LOCKED:  if (!hs_enable) state_next = IDLE;
      ERROR:   if (!hs_enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge byte_clk) begin
    if (byte_rst) begin
      prev_raw   <= 8'd0;
      data       <= 8'd0;
      valid      <= 1'b0;
      sot        <= 1'b0;
      sync_err   <= 1'b0;
      locked     <= 1'b0;
      offset     <= 3'd0;
      hunt_cnt   <= 8'd0;
      first_byte <= 1'b0;
    end else begin
      prev_raw <= (state == IDLE || state == ERROR) ? 8'd0 : raw_data;
      valid    <= 1'b0;
      sot      <= 1'b0;
      sync_err <= 1'b0;
      locked   <= (state_next == LOCKED);
      case (state)
        IDLE: hunt_cnt <= 8'd0;
        HUNT: begin
          if (hs_enable) begin
            if (match) begin
              offset     <= match_k;
              first_byte <= 1'b1;
            end else if (timeout) begin
              sync_err <= 1'b1;
            end else begin
              hunt_cnt <= hunt_cnt + 8'd1;
            end
          end
        end
        // A cycle with hs_enable low is the end of the burst; its window is dropped.
        LOCKED: begin
          if (hs_enable) begin
            data       <= window[offset +: 8];
            valid      <= 1'b1;
            sot        <= first_byte;
            first_byte <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dphy_hs_data_rx_aligner.sv
// Scoreboard bench for dphy_hs_data_rx_aligner: expected payload bytes are
// queued from a bit-level model of each burst and popped by a negedge monitor.
module tb_dphy_hs_data_rx_aligner;

  localparam int LEAD_WORDS = 2;

  logic       byte_clk = 1'b0;
  logic       byte_rst;
  logic       hs_enable;
  logic [7:0] raw_data;
  logic [7:0] data;
  logic       valid, sot, sync_err, locked;
  logic [2:0] offset;

  typedef struct packed {
    logic [7:0] data;
    logic       sot;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   payload [8];
  logic [511:0] stream_bits;
  int           stream_words;

  dphy_hs_data_rx_aligner dut (
    .byte_clk (byte_clk),
    .byte_rst (byte_rst),
    .hs_enable(hs_enable),
    .raw_data (raw_data),
    .data     (data),
    .valid    (valid),
    .sot      (sot),
    .sync_err (sync_err),
    .locked   (locked),
    .offset   (offset)
  );

  always #5 byte_clk = ~byte_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One byte_clk cycle with the given inputs; returns just after the edge.
  task automatic applyStimulus(input logic [7:0] raw, input logic en, input logic rst);
    raw_data  = raw;
    hs_enable = en;
    byte_rst  = rst;
    @(posedge byte_clk);
    #1;
  endtask

  always @(negedge byte_clk) begin : monitor
    exp_t e;
    if (valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_valid: data=%0h sot=%0b, expected no byte", data, sot);
      end else begin
        e = exp_q.pop_front();
        checkOutput("payload_data", {24'd0, data}, {24'd0, e.data});
        checkOutput("payload_sot", {31'd0, sot}, {31'd0, e.sot});
      end
    end else begin
      checkOutput("sot_without_valid", {31'd0, sot}, 32'd0);
    end
  end

  // Serial stream: zero words, then k zero bits, the sync byte LSB first,
  // the payload bytes, and zero trail padded to whole words.
  task automatic buildStream(input int k, input int npay);
    logic [7:0] sync_val;
    int pos;
    sync_val    = 8'hB8;
    stream_bits = '0;
    pos = 8 * LEAD_WORDS + k;
    for (int b = 0; b < 8; b++) stream_bits[pos + b] = sync_val[b];
    for (int p = 0; p < npay; p++)
      for (int b = 0; b < 8; b++) stream_bits[pos + 8 + 8 * p + b] = payload[p][b];
    stream_words = LEAD_WORDS + npay + 3;
  endtask

  task automatic runBurst(input int k, input int npay, input int feed_words, input bit end_burst);
    int nfeed;
    int j;
    exp_t e;
    buildStream(k, npay);
    nfeed = (feed_words < 0) ? stream_words : feed_words;
    for (int i = 0; i < nfeed; i++) begin
      if (i >= LEAD_WORDS + 2) begin
        j      = i - LEAD_WORDS - 2;
        e.data = stream_bits[8 * LEAD_WORDS + k + 8 + 8 * j +: 8];
        e.sot  = (j == 0);
        exp_q.push_back(e);
      end
      applyStimulus(stream_bits[8 * i +: 8], 1'b1, 1'b0);
      if (i == LEAD_WORDS + 1) begin
        checkOutput("lock_locked", {31'd0, locked}, 32'd1);
        checkOutput("lock_offset", {29'd0, offset}, k);
        checkOutput("lock_no_early_valid", {31'd0, valid}, 32'd0);
      end
      if (i == LEAD_WORDS + 2) begin
        checkOutput("latency_valid", {31'd0, valid}, 32'd1);
        checkOutput("latency_sot", {31'd0, sot}, 32'd1);
      end
    end
    if (end_burst) begin
      applyStimulus(8'hFF, 1'b0, 1'b0);
      checkOutput("drop_valid", {31'd0, valid}, 32'd0);
      checkOutput("drop_locked", {31'd0, locked}, 32'd0);
      applyStimulus(8'h00, 1'b0, 1'b0);
    end
  endtask

  // Enter HUNT with a word that never matches and expect one sync_err at HUNT cycle 16.
  task automatic timeoutRun(input logic [7:0] w);
    int pulses;
    pulses = 0;
    applyStimulus(w, 1'b1, 1'b0);
    checkOutput("hunt_entry_err", {31'd0, sync_err}, 32'd0);
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(w, 1'b1, 1'b0);
      checkOutput($sformatf("timeout_err_c%0d", i), {31'd0, sync_err}, (i == 16) ? 32'd1 : 32'd0);
      if (sync_err) pulses++;
    end
    checkOutput("timeout_pulse_count", pulses, 32'd1);
    checkOutput("error_not_locked", {31'd0, locked}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(w, 1'b1, 1'b0);
      checkOutput("error_hold_err", {31'd0, sync_err}, 32'd0);
    end
    applyStimulus(8'h00, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    raw_data  = 8'h00;
    hs_enable = 1'b0;
    byte_rst  = 1'b1;

    applyStimulus(8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 1'b0, 1'b1);
    checkOutput("reset_data", {24'd0, data}, 32'd0);
    checkOutput("reset_valid", {31'd0, valid}, 32'd0);
    checkOutput("reset_sync_err", {31'd0, sync_err}, 32'd0);
    checkOutput("reset_locked", {31'd0, locked}, 32'd0);
    checkOutput("reset_offset", {29'd0, offset}, 32'd0);
    applyStimulus(8'h00, 1'b0, 1'b0);

    payload[0] = 8'h12; payload[1] = 8'h34;
    runBurst(0, 2, -1, 1'b1);

    payload[0] = 8'hA5; payload[1] = 8'h3C;
    runBurst(5, 2, -1, 1'b1);

    // 0x8B8B holds 0xB8 at offset 4 but with a non-zero leader below it.
    timeoutRun(8'h8B);
    payload[0] = 8'h5A; payload[1] = 8'hC3;
    runBurst(1, 2, -1, 1'b1);

    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
    payload[3] = 8'h44; payload[4] = 8'h55;
    runBurst(3, 5, -1, 1'b1);
    payload[0] = 8'h9E; payload[1] = 8'h01;
    runBurst(2, 2, -1, 1'b1);

    payload[0] = 8'hDE; payload[1] = 8'hAD; payload[2] = 8'hBE; payload[3] = 8'hEF;
    runBurst(6, 4, LEAD_WORDS + 5, 1'b0);
    applyStimulus(8'h55, 1'b1, 1'b1);
    checkOutput("midrst_valid", {31'd0, valid}, 32'd0);
    checkOutput("midrst_locked", {31'd0, locked}, 32'd0);
    checkOutput("midrst_offset", {29'd0, offset}, 32'd0);
    checkOutput("midrst_data", {24'd0, data}, 32'd0);
    payload[0] = 8'h77;
    runBurst(7, 1, -1, 1'b1);

    applyStimulus(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h00, 1'b1, 1'b0);
      checkOutput("hunt_drop_err", {31'd0, sync_err}, 32'd0);
    end
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("hunt_drop_idle_err", {31'd0, sync_err}, 32'd0);
    checkOutput("hunt_drop_locked", {31'd0, locked}, 32'd0);
    timeoutRun(8'h00);

    for (int i = 0; i < 4; i++) applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
